// File: rtl/cpu_sys_ctrl.sv
// Multi-core system control slave on AHB-Lite: core enables, timed core
// resets, doorbell interrupts and hardware semaphores.
module cpu_sys_ctrl #(
    parameter int NUM_CPU    = 2,
    parameter int NUM_SEM    = 4,
    parameter int MASTER_W   = 2,
    parameter int RST_CYCLES = 16,
    parameter int EN_RESET   = 1
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic [MASTER_W-1:0] HMASTER,
    output logic                HREADYOUT,
    output logic [31:0]         HRDATA,
    output logic                HRESP,
    output logic [NUM_CPU-1:0]  cpu_en,
    output logic [NUM_CPU-1:0]  cpu_rst,
    output logic [NUM_CPU-1:0]  cpu_irq
);

    logic                                valid_q;
    logic                                write_q;
    logic [5:0]                          off_q;
    logic [3:0]                          mask_q;
    logic [MASTER_W-1:0]                 master_q;

    logic [NUM_CPU-1:0]                  en_q, en_n;
    logic [NUM_CPU-1:0]                  pend_q, pend_n;
    logic [NUM_CPU-1:0][7:0]             cnt_q, cnt_n;
    logic [NUM_CPU-1:0]                  rst_nx;

    logic [NUM_SEM-1:0]                  lock_q, lock_w, lock_n;
    logic [NUM_SEM-1:0][MASTER_W-1:0]    own_q, own_w, own_n;

    logic [5:0]                          off_a;
    logic [3:0]                          mask_a;
    logic                                ap_valid, ap_read, dp_write;
    logic [31:0]                         bmask, wd, rd_n;
    logic                                unused;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign off_a    = HADDR[7:2];
    assign ap_valid = HSEL & HREADY & HTRANS[1];
    assign ap_read  = ap_valid & ~HWRITE;
    assign dp_write = valid_q & write_q;

    assign bmask = {{8{mask_q[3]}}, {8{mask_q[2]}},
                    {8{mask_q[1]}}, {8{mask_q[0]}}};
    assign wd    = HWDATA & bmask;

    assign unused = ^{HADDR[31:8], HTRANS[0], wd};

    // Byte-lane mask of the transfer in its address phase
    always_comb begin
        mask_a = 4'b1111;
        case (HSIZE)
            3'b000:  mask_a = 4'b0001 << HADDR[1:0];
            3'b001:  mask_a = HADDR[1] ? 4'b1100 : 4'b0011;
            default: mask_a = 4'b1111;
        endcase
    end

    // Register next state: counter ticks, data-phase write, then claim
    always_comb begin
        en_n   = en_q;
        pend_n = pend_q;
        for (int i = 0; i < NUM_CPU; i++) begin
            cnt_n[i] = (cnt_q[i] != 8'd0) ? cnt_q[i] - 8'd1 : 8'd0;
        end
        if (dp_write) begin
            case (off_q)
                6'd0: en_n = (en_q & ~bmask[NUM_CPU-1:0])
                           | wd[NUM_CPU-1:0];
                6'd2: begin
                    for (int i = 0; i < NUM_CPU; i++) begin
                        if (wd[i]) cnt_n[i] = 8'(RST_CYCLES);
                    end
                end
                6'd3:    pend_n = pend_q | wd[NUM_CPU-1:0];
                6'd4:    pend_n = pend_q & ~wd[NUM_CPU-1:0];
                default: ;
            endcase
        end
        lock_w = lock_q;
        own_w  = own_q;
        for (int i = 0; i < NUM_SEM; i++) begin
            if (dp_write && off_q == 6'(8 + i) && mask_q[0] &&
                !HWDATA[0] && lock_q[i] && own_q[i] == master_q) begin
                lock_w[i] = 1'b0;
            end
        end
        lock_n = lock_w;
        own_n  = own_w;
        for (int i = 0; i < NUM_SEM; i++) begin
            if (ap_read && off_a == 6'(8 + i) && !lock_w[i]) begin
                lock_n[i] = 1'b1;
                own_n[i]  = HMASTER;
            end
        end
        for (int i = 0; i < NUM_CPU; i++) begin
            rst_nx[i] = (cnt_n[i] != 8'd0);
        end
    end

    // Read data from next state so same-edge writes are visible
    always_comb begin
        rd_n = 32'd0;
        case (off_a)
            6'd0: rd_n = 32'(en_n);
            6'd1: rd_n = 32'(HMASTER);
            6'd2: rd_n = 32'(rst_nx);
            6'd3: rd_n = 32'(pend_n);
            6'd4: rd_n = 32'(pend_n);
            6'd5: rd_n = 32'(lock_w);
            default: begin
                for (int i = 0; i < NUM_SEM; i++) begin
                    if (off_a == 6'(8 + i)) begin
                        rd_n = 32'(!lock_w[i] || own_w[i] == HMASTER);
                    end
                end
            end
        endcase
    end

    // State registers and address-phase capture
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            valid_q  <= 1'b0;
            write_q  <= 1'b0;
            off_q    <= '0;
            mask_q   <= '0;
            master_q <= '0;
            en_q     <= NUM_CPU'(EN_RESET);
            pend_q   <= '0;
            cnt_q    <= '0;
            lock_q   <= '0;
            own_q    <= '0;
            HRDATA   <= '0;
        end else begin
            valid_q  <= ap_valid;
            write_q  <= HWRITE;
            off_q    <= off_a;
            mask_q   <= mask_a;
            master_q <= HMASTER;
            en_q     <= en_n;
            pend_q   <= pend_n;
            cnt_q    <= cnt_n;
            lock_q   <= lock_n;
            own_q    <= own_n;
            if (ap_read) HRDATA <= rd_n;
        end
    end

    // Core-facing outputs
    always_comb begin
        cpu_en  = en_q;
        cpu_irq = pend_q;
        for (int i = 0; i < NUM_CPU; i++) begin
            cpu_rst[i] = (cnt_q[i] != 8'd0);
        end
    end

endmodule

// File: tb/tb_cpu_sys_ctrl.sv
// Bench for cpu_sys_ctrl: directed scenarios plus random bus traffic
// checked against a transaction-level model of the register map.
module tb_cpu_sys_ctrl;

    logic        clk = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [1:0]  HMASTER;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [1:0]  cpu_en, cpu_rst, cpu_irq;

    cpu_sys_ctrl dut (
        .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HMASTER(HMASTER), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .cpu_en(cpu_en),
        .cpu_rst(cpu_rst), .cpu_irq(cpu_irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int          cyc = 0;
    bit [1:0]    m_en;
    bit [1:0]    m_pend;
    int          m_until [2];
    bit          m_lock [4];
    bit [1:0]    m_own [4];
    logic [31:0] m_rd;
    // transfer currently in its data phase
    bit          p_v, p_wr;
    logic [7:0]  p_a;
    logic [2:0]  p_sz;
    logic [31:0] p_d;
    logic [1:0]  p_m;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lanes(input logic [7:0] a,
                                         input logic [2:0] sz);
        int nb, base;
        logic [3:0] l;
        nb   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        base = (int'(a[1:0]) / nb) * nb;
        for (int k = 0; k < 4; k++) l[k] = (k >= base) && (k < base + nb);
        return l;
    endfunction

    task automatic model_reset();
        m_en = 2'b01; m_pend = 2'b00; m_rd = 32'd0; p_v = 1'b0;
        for (int i = 0; i < 2; i++) m_until[i] = 0;
        for (int i = 0; i < 4; i++) begin m_lock[i] = 0; m_own[i] = 0; end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [2:0] sz,
                               input logic [31:0] d, input logic [1:0] m);
        logic [3:0]  l;
        logic [31:0] bm, dm;
        int off, s;
        l  = lanes(a, sz);
        for (int k = 0; k < 32; k++) bm[k] = l[k / 8];
        dm = d & bm;
        off = int'(a) & 'hFC;
        if (off == 'h00) m_en = (m_en & ~bm[1:0]) | dm[1:0];
        else if (off == 'h08) begin
            for (int i = 0; i < 2; i++) if (dm[i]) m_until[i] = cyc + 16;
        end
        else if (off == 'h0C) m_pend = m_pend | dm[1:0];
        else if (off == 'h10) m_pend = m_pend & ~dm[1:0];
        else if (off >= 'h20 && off < 'h30) begin
            s = (off - 'h20) / 4;
            if (l[0] && !d[0] && m_lock[s] && m_own[s] == m) m_lock[s] = 0;
        end
    endtask

    function automatic logic [31:0] rst_vec();
        logic [31:0] r = 0;
        for (int i = 0; i < 2; i++) r[i] = (cyc < m_until[i]);
        return r;
    endfunction

    task automatic model_read(input logic [7:0] a, input logic [1:0] m,
                              output logic [31:0] r);
        int off, s;
        off = int'(a) & 'hFC;
        r = 0;
        if (off == 'h00) r = 32'(m_en);
        else if (off == 'h04) r = 32'(m);
        else if (off == 'h08) r = rst_vec();
        else if (off == 'h0C || off == 'h10) r = 32'(m_pend);
        else if (off == 'h14) begin
            for (int i = 0; i < 4; i++) r[i] = m_lock[i];
        end
        else if (off >= 'h20 && off < 'h30) begin
            s = (off - 'h20) / 4;
            if (!m_lock[s]) begin
                m_lock[s] = 1; m_own[s] = m; r = 1;
            end else r = (m_own[s] == m) ? 1 : 0;
        end
    endtask

    task automatic check_outs();
        chk("cpu_en", 32'(cpu_en), 32'(m_en));
        chk("cpu_irq", 32'(cpu_irq), 32'(m_pend));
        chk("cpu_rst", 32'(cpu_rst), rst_vec());
        chk("hrdata", HRDATA, m_rd);
        chk("hreadyout_hresp", {HREADYOUT, HRESP}, 2'b10);
    endtask

    task automatic bus(input bit sel, input logic [1:0] tr, input bit rdy,
                       input bit wr, input logic [7:0] a,
                       input logic [2:0] sz, input logic [31:0] d,
                       input logic [1:0] m);
        bit v;
        HSEL = sel; HTRANS = tr; HREADY = rdy; HWRITE = wr;
        HADDR = {$urandom_range(0, 255) << 8} | 32'(a);
        HSIZE = sz; HMASTER = m;
        HWDATA = p_d;
        @(posedge clk); #1;
        cyc++;
        if (p_v && p_wr) model_write(p_a, p_sz, p_d, p_m);
        v = sel && rdy && tr[1];
        if (v && !wr) model_read(a, m, m_rd);
        p_v = v; p_wr = wr; p_a = a; p_sz = sz; p_d = d; p_m = m;
        check_outs();
    endtask

    task automatic wr32(input logic [7:0] a, input logic [31:0] d,
                        input logic [1:0] m);
        bus(1, 2'b10, 1, 1, a, 3'd2, d, m);
    endtask

    task automatic rd32(input logic [7:0] a, input logic [1:0] m);
        bus(1, 2'b10, 1, 0, a, 3'd2, $urandom, m);
    endtask

    task automatic idle();
        bus(0, 2'b00, 1, 0, 8'h00, 3'd2, $urandom, 2'd0);
    endtask

    task automatic do_reset(input bit xfer, input logic [7:0] a,
                            input logic [1:0] m);
        HRESET = 1'b1;
        HWDATA = p_d;
        HSEL = xfer; HTRANS = xfer ? 2'b10 : 2'b00; HREADY = 1'b1;
        HWRITE = 1'b0; HADDR = 32'(a); HSIZE = 3'd2; HMASTER = m;
        @(posedge clk); #1;
        cyc++;
        HRESET = 1'b0;
        HSEL = 0; HTRANS = 2'b00;
        model_reset();
        check_outs();
    endtask

    int cnt;
    int r;
    logic [7:0] atab [13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                             8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40,
                             8'h1C};

    initial begin
        HRESET = 1; HSEL = 0; HREADY = 1; HADDR = 0; HTRANS = 0;
        HWRITE = 0; HSIZE = 3'd2; HWDATA = 0; HMASTER = 0;
        p_d = 0;
        model_reset();
        do_reset(0, 8'h00, 2'd0);
        do_reset(0, 8'h00, 2'd0);

        rd32(8'h00, 0); chk("rd_en_reset", HRDATA, 32'h1);
        rd32(8'h14, 0); chk("rd_semstat_reset", HRDATA, 32'h0);
        wr32(8'h00, 32'h3, 0); idle();
        chk("cpu_en_write", 32'(cpu_en), 32'h3);
        bus(1, 2'b10, 1, 1, 8'h01, 3'd0, 32'h0, 0); idle();
        chk("cpu_en_byte1", 32'(cpu_en), 32'h3);
        rd32(8'h04, 2); chk("master_id", HRDATA, 32'h2);

        wr32(8'h08, 32'h2, 0);
        cnt = 0;
        for (int j = 0; j < 30; j++) begin
            idle();
            if (cpu_rst[1]) cnt++;
        end
        chk("rst_pulse_len", cnt, 16);

        wr32(8'h08, 32'h2, 0);
        cnt = 0;
        for (int j = 0; j < 45; j++) begin
            if (j == 9) wr32(8'h08, 32'h2, 0);
            else idle();
            if (cpu_rst[1]) cnt++;
        end
        chk("rst_pulse_ext", cnt, 26);

        wr32(8'h0C, 32'h2, 0); idle();
        chk("db_set", 32'(cpu_irq), 32'h2);
        wr32(8'h10, 32'h2, 0); idle();
        chk("db_clr", 32'(cpu_irq), 32'h0);
        wr32(8'h0C, 32'h2, 0); rd32(8'h0C, 0);
        chk("db_forward", HRDATA, 32'h2);
        wr32(8'h10, 32'h3, 0); idle();

        rd32(8'h20, 1); chk("sem_claim_m1", HRDATA, 32'h1);
        rd32(8'h14, 1); chk("sem_status_1", HRDATA, 32'h1);
        rd32(8'h20, 0); chk("sem_busy_m0", HRDATA, 32'h0);
        wr32(8'h20, 32'h0, 0); idle();
        rd32(8'h14, 0); chk("sem_nonowner_rel", HRDATA, 32'h1);
        wr32(8'h20, 32'h0, 1); idle();
        rd32(8'h14, 0); chk("sem_released", HRDATA, 32'h0);
        rd32(8'h20, 0); chk("sem_claim_m0", HRDATA, 32'h1);
        wr32(8'h20, 32'h0, 0); idle();

        rd32(8'h28, 1); chk("b2b_claim_m1", HRDATA, 32'h1);
        wr32(8'h28, 32'h0, 1); rd32(8'h28, 0);
        chk("b2b_claim_m0", HRDATA, 32'h1);
        rd32(8'h28, 1); chk("b2b_owner", HRDATA, 32'h0);

        wr32(8'h08, 32'h1, 0); idle();
        rd32(8'h24, 1);
        wr32(8'h00, 32'h2, 0);
        chk("pulse_active", 32'(cpu_rst[0]), 32'h1);
        do_reset(1, 8'h2C, 3);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'h0);
        chk("rst_cpu_en", 32'(cpu_en), 32'h1);
        rd32(8'h14, 0); chk("rst_locks", HRDATA, 32'h0);
        rd32(8'h40, 0); chk("unmapped", HRDATA, 32'h0);

        for (int it = 0; it < 800; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                bus($urandom_range(0, 1), 2'($urandom_range(0, 1)), 1, 0,
                    atab[$urandom_range(0, 12)], 3'd2, $urandom, 0);
            end else if (r < 12) begin
                bus(1, 2'b10, 0, $urandom_range(0, 1),
                    atab[$urandom_range(0, 12)], 3'd2, $urandom,
                    2'($urandom_range(0, 3)));
            end else if (r < 13) begin
                do_reset($urandom_range(0, 1), atab[$urandom_range(6, 9)],
                         2'($urandom_range(0, 3)));
            end else begin
                logic [2:0] sz;
                logic [7:0] a;
                sz = 3'($urandom_range(0, 2));
                a  = atab[$urandom_range(0, 12)];
                if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
                else if (sz == 3'd1) a[1:0] = $urandom_range(0, 1) ? 2'd2 : 2'd0;
                bus(1, $urandom_range(0, 1) ? 2'b10 : 2'b11, 1,
                    $urandom_range(0, 1), a, sz,
                    $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF),
                    2'($urandom_range(0, 3)));
            end
        end
        idle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
